// File: rtl/copro_mailbox.sv
// copro_mailbox: C64 -> 6809 byte mailbox.
//
// First-word-fall-through FIFO of 2^DEPTH_LOG2 bytes with a status byte,
// sticky overflow/underflow flags and an optional registered, active-low
// interrupt to the 6809. Build option: define COPRO_MAILBOX_IRQ_EN to
// implement the irq_en register and _irq_09; otherwise _irq_09 is tied high
// and status bit0 reads 0.
//
// Ports:
//   clock, _reset        rising-edge clock, synchronous active-low reset
//   host_wr, host_din    C64 push strobe and data byte
//   host_ctl_wr,host_ctl control write: bit0 irq_en, bit1 flush,
//                        bit5 clear ovf, bit4 clear udf
//   host_status          {full, empty, ovf, udf, 3'b0, irq_en}
//   cpu_rd               6809 pop strobe
//   cpu_dout             head entry, 8'h00 when empty
//   cpu_status           same as host_status
//   count                occupancy 0..2^DEPTH_LOG2
//   _irq_09              registered active-low interrupt request
module copro_mailbox #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  _reset,
  input  logic                  host_wr,
  input  logic [7:0]            host_din,
  input  logic                  host_ctl_wr,
  input  logic [7:0]            host_ctl,
  output logic [7:0]            host_status,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_dout,
  output logic [7:0]            cpu_status,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  _irq_09
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [7:0]            mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_n_q,  irq_n_d;

  logic full, empty, do_flush, push_ok, pop_ok, ovf_set, udf_set;

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign do_flush = host_ctl_wr & host_ctl[1];

  // A push into a full FIFO still completes when a pop frees the head in
  // the same cycle; full implies non-empty, so that pop is always valid.
  always_comb begin
    push_ok = host_wr & (~full | cpu_rd) & ~do_flush;
    pop_ok  = cpu_rd & ~empty & ~do_flush;
    ovf_set = host_wr & full & ~cpu_rd & ~do_flush;
    udf_set = cpu_rd & empty & ~do_flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Clears from the control byte win over a set in the same cycle.
  always_comb begin
    ovf_d = (ovf_q | ovf_set) & ~(host_ctl_wr & host_ctl[5]);
    udf_d = (udf_q | udf_set) & ~(host_ctl_wr & host_ctl[4]);
  end

`ifdef COPRO_MAILBOX_IRQ_EN
  always_comb begin
    irq_en_d = host_ctl_wr ? host_ctl[0] : irq_en_q;
    // Registered from next-state so _irq_09 moves on the same edge as count.
    irq_n_d  = ~(irq_en_d & (count_d != '0));
  end

  logic unused_ctl;
  assign unused_ctl = ^{host_ctl[7:6], host_ctl[3:2]};
`else
  always_comb begin
    irq_en_d = 1'b0;
    irq_n_d  = 1'b1;
  end

  logic unused_ctl;
  assign unused_ctl = ^{host_ctl[7:6], host_ctl[3:2], host_ctl[0], irq_en_d, irq_n_d};
`endif

  always_ff @(posedge clock) begin
    if (!_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef COPRO_MAILBOX_IRQ_EN
  always_ff @(posedge clock) begin
    if (!_reset) begin
      irq_en_q <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      irq_en_q <= irq_en_d;
      irq_n_q  <= irq_n_d;
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq_n_q  = 1'b1;
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (_reset && push_ok) mem_q[wr_ptr_q] <= host_din;
  end

  always_comb begin
    host_status = {full, empty, ovf_q, udf_q, 3'b000, irq_en_q};
    cpu_status  = host_status;
    cpu_dout    = empty ? 8'h00 : mem_q[rd_ptr_q];
    count       = count_q;
    _irq_09     = irq_n_q;
  end

endmodule
